mem_access_ctrl: RTL and testbench

Memory-stage access initiator for the five-stage pipeline: accepts load/store/stack requests from the EX/MEM boundary and drives the data memory's `memRead`/`memWrite`/`addr`/`WD` inputs, sampling its combinational read port. It owns the stack pointer and splits 32-bit stack transfers (PUSH32/POP32) into two 16-bit memory accesses, stalling the pipeline for the extra cycle. Single-word operations complete in one cycle.

---
 rtl/mem_access_ctrl_if.sv | 29 ++
 rtl/mem_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Pipeline request/response and data-memory bus for the memory-stage access initiator.
// master: pipeline/memory side; slave: the access controller.
interface mem_access_ctrl_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 11
);
  logic                   req_valid;
  logic [2:0]             req_op;
  logic [ADDR_SIZE-1:0]   req_addr;
  logic [2*WORD_SIZE-1:0] req_wdata;
  logic                   stall;
  logic                   resp_valid;
  logic [2*WORD_SIZE-1:0] resp_rdata;
  logic                   mem_read;
  logic                   mem_write;
  logic [ADDR_SIZE-1:0]   mem_addr;
  logic [WORD_SIZE-1:0]   mem_wd;
  logic [WORD_SIZE-1:0]   mem_rd;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rd,
    input  stall, resp_valid, resp_rdata, mem_read, mem_write, mem_addr, mem_wd
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rd,
    output stall, resp_valid, resp_rdata, mem_read, mem_write, mem_addr, mem_wd
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage access initiator: loads/stores, stack pointer ownership and
// 32-bit stack transfers split into two 16-bit accesses with a one-cycle stall.
module mem_access_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 11,
  parameter logic [ADDR_SIZE-1:0] SP_RESET = ADDR_SIZE'((2**ADDR_SIZE) - 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_access_ctrl_if.slave     bus,
  output logic [ADDR_SIZE-1:0] sp
);

  typedef enum logic {IDLE, SECOND} state_t;

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_LOAD   = 3'b001,
    OP_STORE  = 3'b010,
    OP_PUSH   = 3'b011,
    OP_POP    = 3'b100,
    OP_PUSH32 = 3'b101,
    OP_POP32  = 3'b110,
    OP_RSVD   = 3'b111
  } op_t;

  state_t                 state, state_nx;
  op_t                    op_in, op_l;
  logic [WORD_SIZE-1:0]   wlo_l, hold_l;
  logic [ADDR_SIZE-1:0]   sp_up;
  logic                   accept, is32_req;
  logic                   sp_inc, sp_dec, rd_first32, rd_final;

  always_comb begin
    op_in    = op_t'(bus.req_op);
    sp_up    = sp + ADDR_SIZE'(1);
    accept   = (state == IDLE) && bus.req_valid && !(op_in inside {OP_NOP, OP_RSVD});
    is32_req = bus.req_valid && (op_in inside {OP_PUSH32, OP_POP32});
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && is32_req) state_nx = SECOND;
      SECOND:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.stall     = ((state == IDLE) && is32_req) || (state == SECOND);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wd    = '0;
    sp_inc        = 1'b0;
    sp_dec        = 1'b0;
    rd_first32    = 1'b0;
    rd_final      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (op_in)
            OP_LOAD: begin
              bus.mem_read = 1'b1;
              bus.mem_addr = bus.req_addr;
              rd_final     = 1'b1;
            end
            OP_STORE: begin
              bus.mem_write = 1'b1;
              bus.mem_addr  = bus.req_addr;
              bus.mem_wd    = bus.req_wdata[WORD_SIZE-1:0];
            end
            OP_PUSH: begin
              bus.mem_write = 1'b1;
              bus.mem_addr  = sp;
              bus.mem_wd    = bus.req_wdata[WORD_SIZE-1:0];
              sp_dec        = 1'b1;
            end
            OP_POP: begin
              bus.mem_read = 1'b1;
              bus.mem_addr = sp_up;
              sp_inc       = 1'b1;
              rd_final     = 1'b1;
            end
            OP_PUSH32: begin
              bus.mem_write = 1'b1;
              bus.mem_addr  = sp;
              bus.mem_wd    = bus.req_wdata[2*WORD_SIZE-1:WORD_SIZE];
              sp_dec        = 1'b1;
            end
            OP_POP32: begin
              bus.mem_read = 1'b1;
              bus.mem_addr = sp_up;
              sp_inc       = 1'b1;
              rd_first32   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      SECOND: begin
        if (op_l == OP_PUSH32) begin
          bus.mem_write = 1'b1;
          bus.mem_addr  = sp;
          bus.mem_wd    = wlo_l;
          sp_dec        = 1'b1;
        end else begin
          bus.mem_read = 1'b1;
          bus.mem_addr = sp_up;
          sp_inc       = 1'b1;
          rd_final     = 1'b1;
        end
      end
      default: ;
    endcase
    // A write presented during reset must not reach the memory.
    if (rst && bus.mem_write) begin
      bus.mem_write = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wd    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp             <= SP_RESET;
      op_l           <= OP_NOP;
      wlo_l          <= '0;
      hold_l         <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      if (sp_dec)      sp <= sp - ADDR_SIZE'(1);
      else if (sp_inc) sp <= sp_up;
      if (accept) begin
        op_l  <= op_in;
        wlo_l <= bus.req_wdata[WORD_SIZE-1:0];
      end
      if (rd_first32) hold_l <= bus.mem_rd;
      bus.resp_valid <= rd_final;
      if (rd_final) begin
        if (state == SECOND) bus.resp_rdata <= {bus.mem_rd, hold_l};
        else                 bus.resp_rdata <= {{WORD_SIZE{1'b0}}, bus.mem_rd};
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-level model of
// the stack/memory semantics, with a per-cycle compare process.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] sp;

  mem_access_ctrl_if #(.WORD_SIZE(16), .ADDR_SIZE(11)) bus ();

  mem_access_ctrl #(.WORD_SIZE(16), .ADDR_SIZE(11), .SP_RESET(11'h7FF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .sp  (sp)
  );

  always #5 clk = ~clk;

  // Environment data memory: combinational read, write committed on negedge.
  logic [15:0] env_mem [0:2047];
  assign bus.mem_rd = env_mem[bus.mem_addr];
  always @(negedge clk) if (bus.mem_write) env_mem[bus.mem_addr] <= bus.mem_wd;

  // Reference model state.
  logic [15:0] m_mem [0:2047];
  logic [10:0] m_sp;
  bit          pend_v;
  logic [31:0] pend_d;

  // Expected outputs for the current cycle.
  logic        exp_stall, exp_rd, exp_wr, exp_rv;
  logic [10:0] exp_addr, exp_sp;
  logic [15:0] exp_wd;
  logic [31:0] exp_rdata;
  int          chk_mode = 0;  // 0 none, 1 reset cycle, 2 full

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_mode == 1) begin
      chk("mem_write_in_reset", 32'(bus.mem_write), 32'(1'b0));
    end else if (chk_mode == 2) begin
      chk("stall",      32'(bus.stall),      32'(exp_stall));
      chk("mem_read",   32'(bus.mem_read),   32'(exp_rd));
      chk("mem_write",  32'(bus.mem_write),  32'(exp_wr));
      chk("mem_addr",   32'(bus.mem_addr),   32'(exp_addr));
      chk("mem_wd",     32'(bus.mem_wd),     32'(exp_wd));
      chk("sp",         32'(sp),             32'(exp_sp));
      chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
      chk("resp_rdata", bus.resp_rdata,      exp_rdata);
    end
  end

  // One clock cycle with the given expected memory access.
  task automatic cyc(input bit st, input bit rd, input bit wr,
                     input logic [10:0] ad, input logic [15:0] d);
    exp_stall = st;
    exp_rd    = rd;
    exp_wr    = wr;
    exp_addr  = ad;
    exp_wd    = d;
    exp_sp    = m_sp;
    exp_rv    = pend_v;
    if (pend_v) exp_rdata = pend_d;
    pend_v    = 1'b0;
    chk_mode  = 2;
    @(posedge clk); #1;
  endtask

  task automatic set_resp(input logic [31:0] d);
    pend_v = 1'b1;
    pend_d = d;
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    chk_mode = 1;
    repeat (n) begin @(posedge clk); #1; end
    rst       = 1'b0;
    m_sp      = 11'h7FF;
    pend_v    = 1'b0;
    exp_rdata = '0;
  endtask

  task automatic drive(input bit v, input logic [2:0] op,
                       input logic [10:0] a, input logic [31:0] wd);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_wdata = wd;
  endtask

  // Issue one request and walk through the cycles it must take.
  task automatic issue(input bit v, input logic [2:0] op,
                       input logic [10:0] a, input logic [31:0] wd);
    logic [10:0] s1;
    logic [15:0] lo;
    drive(v, op, a, wd);
    if (!v || op == 3'd0 || op == 3'd7) begin
      cyc(0, 0, 0, '0, '0);
    end else begin
      case (op)
        3'd1: begin
          cyc(0, 1, 0, a, '0);
          set_resp({16'h0, m_mem[a]});
        end
        3'd2: begin
          cyc(0, 0, 1, a, wd[15:0]);
          m_mem[a] = wd[15:0];
        end
        3'd3: begin
          cyc(0, 0, 1, m_sp, wd[15:0]);
          m_mem[m_sp] = wd[15:0];
          m_sp = m_sp - 11'd1;
        end
        3'd4: begin
          s1 = m_sp + 11'd1;
          cyc(0, 1, 0, s1, '0);
          set_resp({16'h0, m_mem[s1]});
          m_sp = s1;
        end
        3'd5: begin
          cyc(1, 0, 1, m_sp, wd[31:16]);
          m_mem[m_sp] = wd[31:16];
          m_sp = m_sp - 11'd1;
          cyc(1, 0, 1, m_sp, wd[15:0]);
          m_mem[m_sp] = wd[15:0];
          m_sp = m_sp - 11'd1;
        end
        default: begin
          s1 = m_sp + 11'd1;
          cyc(1, 1, 0, s1, '0);
          lo = m_mem[s1];
          m_sp = s1;
          s1 = m_sp + 11'd1;
          cyc(1, 1, 0, s1, '0);
          set_resp({m_mem[s1], lo});
          m_sp = s1;
        end
      endcase
    end
  endtask

  initial begin
    logic [15:0] v;
    for (int i = 0; i < 2048; i++) begin
      v = 16'($urandom);
      env_mem[i] <= v;
      m_mem[i] = v;
    end
    rst = 1'b1;
    drive(0, 3'd0, '0, '0);
    m_sp = 11'h7FF;
    pend_v = 1'b0;
    exp_rdata = '0;
    @(posedge clk); #1;
    do_reset(2);

    // Reset values, then STORE/LOAD.
    issue(0, 3'd0, '0, '0);
    issue(1, 3'd2, 11'h010, 32'h0000BEEF);
    issue(1, 3'd1, 11'h010, '0);
    issue(0, 3'd0, '0, '0);
    chk("pin_load_rdata", bus.resp_rdata, 32'h0000BEEF);

    // PUSH / POP.
    issue(1, 3'd3, '0, 32'h00001234);
    chk("pin_push_mem", 32'(env_mem[11'h7FF]), 32'h1234);
    chk("pin_push_sp", 32'(sp), 32'h7FE);
    issue(1, 3'd4, '0, '0);
    issue(0, 3'd0, '0, '0);
    chk("pin_pop_rdata", bus.resp_rdata, 32'h00001234);
    chk("pin_pop_sp", 32'(sp), 32'h7FF);

    // PUSH32 / POP32 back to back.
    issue(1, 3'd5, '0, 32'hAAAA5555);
    chk("pin_push32_hi", 32'(env_mem[11'h7FF]), 32'hAAAA);
    chk("pin_push32_lo", 32'(env_mem[11'h7FE]), 32'h5555);
    chk("pin_push32_sp", 32'(sp), 32'h7FD);
    issue(1, 3'd6, '0, '0);
    issue(0, 3'd0, '0, '0);
    chk("pin_pop32_rdata", bus.resp_rdata, 32'hAAAA5555);
    chk("pin_pop32_sp", 32'(sp), 32'h7FF);

    // Stack pointer wrap.
    do_reset(1);
    issue(1, 3'd4, '0, '0);
    chk("pin_wrap_pop_sp", 32'(sp), 32'h000);
    issue(1, 3'd3, '0, 32'h0000C0DE);
    chk("pin_wrap_push_mem", 32'(env_mem[11'h000]), 32'hC0DE);
    chk("pin_wrap_push_sp", 32'(sp), 32'h7FF);

    // Reset during the second half of PUSH32.
    drive(1, 3'd5, '0, 32'h11112222);
    cyc(1, 0, 1, m_sp, 16'h1111);
    m_mem[m_sp] = 16'h1111;
    m_sp = m_sp - 11'd1;
    do_reset(1);
    issue(0, 3'd0, '0, '0);
    chk("pin_rst2nd_mem", 32'(env_mem[11'h7FF]), 32'h1111);

    // Reserved op and NOP with valid.
    issue(1, 3'd7, 11'h123, 32'hFFFFFFFF);
    issue(1, 3'd0, 11'h123, 32'hFFFFFFFF);

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0)
        do_reset(1 + int'($urandom_range(0, 1)));
      else
        issue($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)),
              11'($urandom), $urandom);
    end
    issue(0, 3'd0, '0, '0);
    issue(0, 3'd0, '0, '0);

    begin
      int bad = 0;
      for (int i = 0; i < 2048; i++) if (env_mem[i] !== m_mem[i]) bad++;
      chk("memory_image", 32'(bad), 32'd0);
    end

    chk_mode = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
